// File: rtl/dw_conv_line_buf_if.sv
// Pixel stream into the line buffer and 3-tap vertical column stream out of it.
// The master side is the pixel source/column consumer; the slave side is the buffer.
interface dw_conv_line_buf_if #(
  parameter int CH_NUM     = 18,
  parameter int DATA_WIDTH = 8
);
  logic                             valid_in;
  logic [CH_NUM*DATA_WIDTH-1:0]     data_in;
  logic [CH_NUM*3*DATA_WIDTH-1:0]   data_out;
  logic                             valid_out;
  logic                             sol_out;
  logic                             eof_out;

  modport master (
    output valid_in, data_in,
    input  data_out, valid_out, sol_out, eof_out
  );

  modport slave (
    input  valid_in, data_in,
    output data_out, valid_out, sol_out, eof_out
  );
endinterface

// File: rtl/dw_conv_line_buf.sv
// Two-row line buffer feeding a 3x3 depthwise window generator: for every accepted
// pixel from row 2 onward it emits the vertical column {row y-2, row y-1, row y}.
module dw_conv_line_buf #(
  parameter int CH_NUM     = 18,
  parameter int DATA_WIDTH = 8,
  parameter int IMG_WIDTH  = 32,
  parameter int IMG_HEIGHT = 32
) (
  input  logic              clk,
  input  logic              rst,
  dw_conv_line_buf_if.slave pix
);
  localparam int PIX_W = CH_NUM * DATA_WIDTH;
  localparam int COL_OUT_W = CH_NUM * 3 * DATA_WIDTH;
  localparam int COL_W = $clog2(IMG_WIDTH);
  localparam int ROW_W = $clog2(IMG_HEIGHT);
  localparam logic [COL_W-1:0] LAST_COL  = COL_W'(IMG_WIDTH - 1);
  localparam logic [ROW_W-1:0] LAST_ROW  = ROW_W'(IMG_HEIGHT - 1);
  localparam logic [ROW_W-1:0] FIRST_OUT_ROW = ROW_W'(2);

  // Row storage carries no reset; stale rows are never exposed because rows 0/1
  // of every frame refill both buffers before any column is flagged valid.
  logic [PIX_W-1:0]     lb0_q [IMG_WIDTH];
  logic [PIX_W-1:0]     lb1_q [IMG_WIDTH];

  logic [COL_W-1:0]     col_q, col_d;
  logic [ROW_W-1:0]     row_q, row_d;
  logic [COL_OUT_W-1:0] data_q, data_d;
  logic                 valid_q, valid_d;
  logic                 sol_q, sol_d;
  logic                 eof_q, eof_d;

  logic [PIX_W-1:0]     tap0, tap1;
  logic [COL_OUT_W-1:0] column;
  logic                 accept;
  logic                 last_col, last_row;

  assign accept   = pix.valid_in;
  assign last_col = (col_q == LAST_COL);
  assign last_row = (row_q == LAST_ROW);

  // Reads use pre-write contents, giving read-before-write at the shared address.
  assign tap0 = lb0_q[col_q];
  assign tap1 = lb1_q[col_q];

  always_comb begin
    column = '0;
    for (int unsigned c = 0; c < CH_NUM; c++) begin
      column[(c*3 + 0)*DATA_WIDTH +: DATA_WIDTH] = tap0[c*DATA_WIDTH +: DATA_WIDTH];
      column[(c*3 + 1)*DATA_WIDTH +: DATA_WIDTH] = tap1[c*DATA_WIDTH +: DATA_WIDTH];
      column[(c*3 + 2)*DATA_WIDTH +: DATA_WIDTH] = pix.data_in[c*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  always_comb begin
    col_d   = col_q;
    row_d   = row_q;
    data_d  = data_q;
    valid_d = 1'b0;
    sol_d   = 1'b0;
    eof_d   = 1'b0;
    if (accept) begin
      data_d  = column;
      valid_d = (row_q >= FIRST_OUT_ROW);
      sol_d   = (row_q >= FIRST_OUT_ROW) && (col_q == '0);
      eof_d   = last_row && last_col;
      if (last_col) begin
        col_d = '0;
        row_d = last_row ? '0 : row_q + ROW_W'(1);
      end else begin
        col_d = col_q + COL_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      col_q   <= '0;
      row_q   <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      sol_q   <= 1'b0;
      eof_q   <= 1'b0;
    end else begin
      col_q   <= col_d;
      row_q   <= row_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      sol_q   <= sol_d;
      eof_q   <= eof_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && accept) begin
      lb0_q[col_q] <= lb1_q[col_q];
      lb1_q[col_q] <= pix.data_in;
    end
  end

  assign pix.data_out  = data_q;
  assign pix.valid_out = valid_q;
  assign pix.sol_out   = sol_q;
  assign pix.eof_out   = eof_q;
endmodule
